maze_path_sequencer: RTL and testbench
======================================

MAZE_PATH_SEQUENCER -- requirements
Module: maze_path_sequencer

Interface
REQ-001 Parameter: DIST_TIMEOUT, 4000, max cycles spent waiting for dist_done before abort.
REQ-002 Parameter: INF, 7'd127, distance code meaning unreachable/wall.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request to solve; sampled only in IDLE.
REQ-006 start_row, start_col  input  4 each  start cell; row-major index = row*10+col.
REQ-007 dist_en  output  1  enable to distance-map engine.
REQ-008 dist_done  input  1  distance map valid.
REQ-009 dist_table  input  7 x [0:99]  per-cell distance to goal (0 = goal, INF = unreachable).
REQ-010 mv_valid  output  1  move available.
REQ-011 mv_ready  input  1  consumer accepts move.
REQ-012 mv_dir  output  2  00 up (row-1), 01 down (row+1), 10 left (col-1), 11 right (col+1).
REQ-013 cur_row, cur_col  output  4 each  walker position.
REQ-014 step_cnt  output  7  moves accepted this run.
REQ-015 busy  output  1  high in any state except IDLE.
REQ-016 done  output  1  one-cycle pulse at end of run.
REQ-017 status  output  2  00 goal reached, 01 unreachable, 10 timeout, 11 bad start; held until next start.

Function
REQ-018 States SHALL be IDLE, MAP, CHECK, EMIT, FIN; all outputs registered.
REQ-019 IDLE: on start, if start_row>9 or start_col>9 -> FIN with status 11, dist_en never raised; else latch cur_row/cur_col, clear step_cnt and timeout counter, set dist_en=1, -> MAP.
REQ-020 start SHALL be ignored outside IDLE.
REQ-021 MAP: timeout counter increments each cycle; dist_done=1 -> CHECK; counter reaching DIST_TIMEOUT-1 without dist_done -> FIN with status 10.
REQ-022 CHECK (one cycle): d = dist_table[cur]; d==0 -> FIN status 00; d==INF -> FIN status 01.
REQ-023 CHECK otherwise: select first in-bounds neighbor in priority up, down, left, right with dist == d-1; latch mv_dir, -> EMIT; none found -> FIN status 01.
REQ-024 EMIT: mv_valid=1, mv_dir stable; on mv_valid&&mv_ready update cur per mv_dir, step_cnt+1, mv_valid=0, -> CHECK.
REQ-025 mv_valid and mv_dir SHALL NOT change while mv_ready is low.
REQ-026 step_cnt saturates at 127; reaching 127 without goal -> FIN status 01.
REQ-027 dist_en SHALL stay 1 from MAP entry through CHECK/EMIT and be 0 in FIN and IDLE, giving the engine at least one low cycle between runs.
REQ-028 FIN (one cycle): done=1, dist_en=0, -> IDLE.
REQ-029 dist_table SHALL be read only in CHECK; no other input is sampled mid-run.

Reset
REQ-030 On rst: state IDLE, dist_en=0, mv_valid=0, mv_dir=00, cur_row=cur_col=0, step_cnt=0, busy=0, done=0, status=00, timeout counter=0.
REQ-031 rst asserted in any state SHALL abort immediately; no partial move is accepted after rst.

Verification
REQ-032 Open maze (Manhattan table to goal (0,9)), start (9,0), mv_ready=1 -> 18 moves, 9x up then 9x right, status 00, step_cnt 18, one done pulse.
REQ-033 Start (0,9) -> dist_en high until FIN, zero moves, status 00, step_cnt 0.
REQ-034 Start cell dist=INF -> no mv_valid, status 01, done pulse.
REQ-035 dist_done held 0, DIST_TIMEOUT=16 -> FIN 16 cycles after MAP entry, status 10, dist_en low in FIN.
REQ-036 start_row=10 -> status 11 two cycles after start, dist_en never 1.
REQ-037 mv_ready low 5 cycles during EMIT -> mv_valid/mv_dir stable 5 cycles, cur unchanged; rst mid-EMIT -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/maze_path_sequencer_if.sv
// Move handshake channel between the maze path sequencer and its move consumer.
interface maze_path_sequencer_if;
  logic       mv_valid;
  logic       mv_ready;
  logic [1:0] mv_dir;

  modport master (output mv_valid, output mv_dir, input mv_ready);
  modport slave  (input mv_valid, input mv_dir, output mv_ready);
endinterface

// File: rtl/maze_path_sequencer.sv
// Walks a 10x10 maze from a start cell to the goal by descending a distance map,
// emitting one move per accepted handshake on the move channel.
module maze_path_sequencer #(
  parameter int         DIST_TIMEOUT = 4000,
  parameter logic [6:0] INF          = 7'd127
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [3:0]            start_row,
  input  logic [3:0]            start_col,
  output logic                  dist_en,
  input  logic                  dist_done,
  input  logic [6:0]            dist_table [0:99],
  maze_path_sequencer_if.master mv,
  output logic [3:0]            cur_row,
  output logic [3:0]            cur_col,
  output logic [6:0]            step_cnt,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            status
);

  localparam int TW = $clog2(DIST_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, MAP, CHECK, EMIT, FIN} state_t;

  state_t          state, state_n;
  logic [TW-1:0]   tmo, tmo_n;
  logic            dist_en_n, mv_valid_n, busy_n, done_n;
  logic [1:0]      mv_dir_n, status_n;
  logic [3:0]      cur_row_n, cur_col_n;
  logic [6:0]      step_n;
  logic [6:0]      chk_idx, chk_d, chk_t;
  logic            nb_found;
  logic [1:0]      nb_dir;

  function automatic logic [6:0] cell_idx(input logic [3:0] r, input logic [3:0] c);
    return ({3'b000, r} * 7'd10) + {3'b000, c};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      tmo         <= '0;
      dist_en     <= 1'b0;
      mv.mv_valid <= 1'b0;
      mv.mv_dir   <= 2'b00;
      cur_row     <= 4'd0;
      cur_col     <= 4'd0;
      step_cnt    <= 7'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      status      <= 2'b00;
    end else begin
      state       <= state_n;
      tmo         <= tmo_n;
      dist_en     <= dist_en_n;
      mv.mv_valid <= mv_valid_n;
      mv.mv_dir   <= mv_dir_n;
      cur_row     <= cur_row_n;
      cur_col     <= cur_col_n;
      step_cnt    <= step_n;
      busy        <= busy_n;
      done        <= done_n;
      status      <= status_n;
    end
  end

  always_comb begin
    state_n    = state;
    tmo_n      = tmo;
    mv_valid_n = mv.mv_valid;
    mv_dir_n   = mv.mv_dir;
    cur_row_n  = cur_row;
    cur_col_n  = cur_col;
    step_n     = step_cnt;
    status_n   = status;
    chk_idx    = cell_idx(cur_row, cur_col);
    chk_d      = 7'd0;
    chk_t      = 7'd0;
    nb_found   = 1'b0;
    nb_dir     = 2'b00;

    case (state)
      IDLE: begin
        if (start) begin
          if (start_row > 4'd9 || start_col > 4'd9) begin
            state_n  = FIN;
            status_n = 2'b11;
          end else begin
            state_n   = MAP;
            cur_row_n = start_row;
            cur_col_n = start_col;
            step_n    = 7'd0;
            tmo_n     = '0;
          end
        end
      end
      MAP: begin
        if (dist_done) begin
          state_n = CHECK;
        end else if (tmo == TW'(DIST_TIMEOUT - 1)) begin
          state_n  = FIN;
          status_n = 2'b10;
        end else begin
          tmo_n = tmo + 1'b1;
        end
      end
      CHECK: begin
        chk_d = dist_table[chk_idx];
        chk_t = chk_d - 7'd1;
        // Neighbour priority up, down, left, right; the first one strictly downhill wins.
        if (cur_row != 4'd0 && dist_table[chk_idx - 7'd10] == chk_t) begin
          nb_found = 1'b1; nb_dir = 2'b00;
        end else if (cur_row != 4'd9 && dist_table[chk_idx + 7'd10] == chk_t) begin
          nb_found = 1'b1; nb_dir = 2'b01;
        end else if (cur_col != 4'd0 && dist_table[chk_idx - 7'd1] == chk_t) begin
          nb_found = 1'b1; nb_dir = 2'b10;
        end else if (cur_col != 4'd9 && dist_table[chk_idx + 7'd1] == chk_t) begin
          nb_found = 1'b1; nb_dir = 2'b11;
        end
        if (chk_d == 7'd0) begin
          state_n  = FIN;
          status_n = 2'b00;
        end else if (chk_d == INF || step_cnt == 7'd127 || !nb_found) begin
          state_n  = FIN;
          status_n = 2'b01;
        end else begin
          state_n    = EMIT;
          mv_dir_n   = nb_dir;
          mv_valid_n = 1'b1;
        end
      end
      EMIT: begin
        if (mv.mv_ready) begin
          state_n    = CHECK;
          mv_valid_n = 1'b0;
          step_n     = (step_cnt == 7'd127) ? step_cnt : step_cnt + 7'd1;
          case (mv.mv_dir)
            2'b00:   cur_row_n = cur_row - 4'd1;
            2'b01:   cur_row_n = cur_row + 4'd1;
            2'b10:   cur_col_n = cur_col - 4'd1;
            default: cur_col_n = cur_col + 4'd1;
          endcase
        end
      end
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // The engine enable drops in FIN so it always sees a low cycle between runs.
    dist_en_n = (state_n == MAP) || (state_n == CHECK) || (state_n == EMIT);
    busy_n    = (state_n != IDLE);
    done_n    = (state_n == FIN);
  end

endmodule

// File: tb/tb_maze_path_sequencer.sv
// Self-checking bench for maze_path_sequencer using a move scoreboard.
module tb_maze_path_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] start_row, start_col;
  logic       dist_en, dist_done;
  logic [6:0] tbl [0:99];
  logic [3:0] cur_row, cur_col;
  logic [6:0] step_cnt;
  logic       busy, done;
  logic [1:0] status;

  maze_path_sequencer_if mv_if ();

  maze_path_sequencer #(.DIST_TIMEOUT(16), .INF(7'd127)) dut (
    .clk(clk), .rst(rst), .start(start), .start_row(start_row), .start_col(start_col),
    .dist_en(dist_en), .dist_done(dist_done), .dist_table(tbl), .mv(mv_if),
    .cur_row(cur_row), .cur_col(cur_col), .step_cnt(step_cnt),
    .busy(busy), .done(done), .status(status)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] dir;
    logic [3:0] row;
    logic [3:0] col;
  } mv_t;

  mv_t sb[$];
  int  compared   = 0;
  int  mismatched = 0;

  task automatic fill_manhattan();
    for (int r = 0; r < 10; r++)
      for (int c = 0; c < 10; c++)
        tbl[r*10+c] = 7'(r + (9 - c));
  endtask

  task automatic fill_inf();
    for (int i = 0; i < 100; i++) tbl[i] = 7'd127;
  endtask

  task automatic pulse_start(input logic [3:0] r, input logic [3:0] c);
    @(posedge clk); #1;
    start_row = r; start_col = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Observes a run after pulse_start; gathers counts only.
  task automatic run_collect(input int limit, output int ndone, output int nmv,
                             output int en_bad, output int en_cycles, output int first_done);
    int post;
    ndone = 0; nmv = 0; en_bad = 0; en_cycles = 0; first_done = -1; post = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (mv_if.mv_valid) nmv++;
      if (busy && !done) begin
        if (dist_en) en_cycles++; else en_bad++;
      end
      if (!busy && dist_en) en_bad++;
      if (done) begin
        ndone++;
        if (first_done < 0) first_done = i;
        if (dist_en) en_bad++;
      end
      if (ndone > 0) post++;
      if (post == 4) break;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; start_row = 4'd0; start_col = 4'd0;
    dist_done = 1'b0; mv_if.mv_ready = 1'b0;
    fill_manhattan();
    repeat (2) @(posedge clk);
    @(negedge clk);
    compared++; if (dist_en !== 1'b0) begin mismatched++; $display("FAIL reset_dist_en got %b want 0", dist_en); end
    compared++; if (mv_if.mv_valid !== 1'b0) begin mismatched++; $display("FAIL reset_mv_valid got %b want 0", mv_if.mv_valid); end
    compared++; if (mv_if.mv_dir !== 2'b00) begin mismatched++; $display("FAIL reset_mv_dir got %b want 00", mv_if.mv_dir); end
    compared++; if (cur_row !== 4'd0 || cur_col !== 4'd0) begin mismatched++; $display("FAIL reset_cur got %0d,%0d want 0,0", cur_row, cur_col); end
    compared++; if (step_cnt !== 7'd0) begin mismatched++; $display("FAIL reset_step got %0d want 0", step_cnt); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy got %b want 0", busy); end
    compared++; if (done !== 1'b0) begin mismatched++; $display("FAIL reset_done got %b want 0", done); end
    compared++; if (status !== 2'b00) begin mismatched++; $display("FAIL reset_status got %b want 00", status); end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_open_maze();
    int  ndone, post, en_bad;
    mv_t e;
    fill_manhattan();
    dist_done = 1'b1; mv_if.mv_ready = 1'b1;
    sb.delete();
    for (int i = 0; i < 9; i++) sb.push_back('{2'b00, 4'(9 - i), 4'd0});
    for (int i = 0; i < 9; i++) sb.push_back('{2'b11, 4'd0, 4'(i)});
    pulse_start(4'd9, 4'd0);
    ndone = 0; post = 0; en_bad = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (busy && !done && !dist_en) en_bad++;
      if (mv_if.mv_valid && mv_if.mv_ready) begin
        compared++;
        if (sb.size() == 0) begin
          mismatched++; $display("FAIL open_extra_move got dir %b at %0d,%0d want none", mv_if.mv_dir, cur_row, cur_col);
        end else begin
          e = sb.pop_front();
          if (mv_if.mv_dir !== e.dir || cur_row !== e.row || cur_col !== e.col) begin
            mismatched++;
            $display("FAIL open_move got dir %b at %0d,%0d want dir %b at %0d,%0d",
                     mv_if.mv_dir, cur_row, cur_col, e.dir, e.row, e.col);
          end
        end
      end
      if (done) begin
        ndone++;
        compared++; if (dist_en !== 1'b0) begin mismatched++; $display("FAIL open_fin_dist_en got %b want 0", dist_en); end
      end
      if (ndone > 0) post++;
      if (post == 5) break;
    end
    compared++; if (ndone !== 1) begin mismatched++; $display("FAIL open_done_pulses got %0d want 1", ndone); end
    compared++; if (status !== 2'b00) begin mismatched++; $display("FAIL open_status got %b want 00", status); end
    compared++; if (step_cnt !== 7'd18) begin mismatched++; $display("FAIL open_step got %0d want 18", step_cnt); end
    compared++; if (sb.size() != 0) begin mismatched++; $display("FAIL open_missing_moves got %0d left want 0", sb.size()); end
    compared++; if (en_bad !== 0) begin mismatched++; $display("FAIL open_dist_en_drop got %0d want 0", en_bad); end
  endtask

  task automatic test_at_goal();
    int ndone, nmv, en_bad, en_cycles, first_done;
    fill_manhattan();
    dist_done = 1'b1; mv_if.mv_ready = 1'b1;
    pulse_start(4'd0, 4'd9);
    run_collect(100, ndone, nmv, en_bad, en_cycles, first_done);
    compared++; if (nmv !== 0) begin mismatched++; $display("FAIL goal_moves got %0d want 0", nmv); end
    compared++; if (en_cycles !== 2 || en_bad !== 0) begin mismatched++; $display("FAIL goal_dist_en got %0d high/%0d bad want 2/0", en_cycles, en_bad); end
    compared++; if (ndone !== 1 || first_done !== 2) begin mismatched++; $display("FAIL goal_done got %0d at %0d want 1 at 2", ndone, first_done); end
    compared++; if (status !== 2'b00 || step_cnt !== 7'd0) begin mismatched++; $display("FAIL goal_result got %b/%0d want 00/0", status, step_cnt); end
  endtask

  task automatic test_unreachable();
    int ndone, nmv, en_bad, en_cycles, first_done;
    fill_manhattan();
    tbl[55] = 7'd127;
    dist_done = 1'b1; mv_if.mv_ready = 1'b1;
    pulse_start(4'd5, 4'd5);
    run_collect(100, ndone, nmv, en_bad, en_cycles, first_done);
    compared++; if (nmv !== 0) begin mismatched++; $display("FAIL unreach_moves got %0d want 0", nmv); end
    compared++; if (ndone !== 1) begin mismatched++; $display("FAIL unreach_done got %0d want 1", ndone); end
    compared++; if (status !== 2'b01) begin mismatched++; $display("FAIL unreach_status got %b want 01", status); end
  endtask

  task automatic test_dead_end();
    int ndone, nmv, en_bad, en_cycles, first_done;
    fill_inf();
    tbl[33] = 7'd5;
    tbl[23] = 7'd6;
    dist_done = 1'b1; mv_if.mv_ready = 1'b1;
    pulse_start(4'd3, 4'd3);
    run_collect(100, ndone, nmv, en_bad, en_cycles, first_done);
    compared++; if (nmv !== 0 || ndone !== 1) begin mismatched++; $display("FAIL deadend_run got %0d moves %0d done want 0/1", nmv, ndone); end
    compared++; if (status !== 2'b01) begin mismatched++; $display("FAIL deadend_status got %b want 01", status); end
  endtask

  task automatic test_timeout();
    int ndone, nmv, en_bad, en_cycles, first_done;
    fill_manhattan();
    dist_done = 1'b0; mv_if.mv_ready = 1'b1;
    pulse_start(4'd9, 4'd0);
    run_collect(100, ndone, nmv, en_bad, en_cycles, first_done);
    compared++; if (ndone !== 1 || first_done !== 16) begin mismatched++; $display("FAIL timeout_latency got %0d at %0d want 1 at 16", ndone, first_done); end
    compared++; if (en_cycles !== 16 || en_bad !== 0) begin mismatched++; $display("FAIL timeout_dist_en got %0d high/%0d bad want 16/0", en_cycles, en_bad); end
    compared++; if (status !== 2'b10) begin mismatched++; $display("FAIL timeout_status got %b want 10", status); end
    dist_done = 1'b1;
  endtask

  task automatic test_bad_start();
    int ndone, nmv, en_bad, en_cycles, first_done;
    fill_manhattan();
    dist_done = 1'b1; mv_if.mv_ready = 1'b1;
    pulse_start(4'd10, 4'd0);
    run_collect(20, ndone, nmv, en_bad, en_cycles, first_done);
    compared++; if (ndone !== 1 || first_done !== 0) begin mismatched++; $display("FAIL badstart_done got %0d at %0d want 1 at 0", ndone, first_done); end
    compared++; if (en_cycles !== 0 || en_bad !== 0) begin mismatched++; $display("FAIL badstart_dist_en got %0d high/%0d bad want 0/0", en_cycles, en_bad); end
    compared++; if (status !== 2'b11 || nmv !== 0) begin mismatched++; $display("FAIL badstart_status got %b/%0d moves want 11/0", status, nmv); end
  endtask

  task automatic test_backpressure();
    int         seen, bad;
    logic [1:0] dir0;
    mv_t        e;
    fill_manhattan();
    dist_done = 1'b1; mv_if.mv_ready = 1'b0;
    sb.delete();
    sb.push_back('{2'b00, 4'd9, 4'd0});
    pulse_start(4'd9, 4'd0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mv_if.mv_valid) begin seen = 1; break; end
    end
    compared++; if (seen !== 1) begin mismatched++; $display("FAIL bp_first_valid got %0d want 1", seen); end
    dir0 = mv_if.mv_dir;
    start = 1'b1; start_row = 4'd0; start_col = 4'd0;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (mv_if.mv_valid !== 1'b1 || mv_if.mv_dir !== dir0 || cur_row !== 4'd9 || cur_col !== 4'd0 || step_cnt !== 7'd0) bad++;
    end
    compared++; if (bad !== 0) begin mismatched++; $display("FAIL bp_hold_stable got %0d unstable cycles want 0", bad); end
    mv_if.mv_ready = 1'b1;
    e = sb.pop_front();
    compared++;
    if (mv_if.mv_dir !== e.dir || cur_row !== e.row || cur_col !== e.col) begin
      mismatched++; $display("FAIL bp_move got dir %b at %0d,%0d want dir %b at %0d,%0d", mv_if.mv_dir, cur_row, cur_col, e.dir, e.row, e.col);
    end
    @(posedge clk); #1;
    mv_if.mv_ready = 1'b0; start = 1'b0;
    @(negedge clk);
    compared++; if (cur_row !== 4'd8 || cur_col !== 4'd0 || step_cnt !== 7'd1) begin mismatched++; $display("FAIL bp_after_accept got %0d,%0d step %0d want 8,0 step 1", cur_row, cur_col, step_cnt); end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mv_if.mv_valid) begin seen = 1; break; end
    end
    compared++; if (seen !== 1) begin mismatched++; $display("FAIL bp_second_valid got %0d want 1", seen); end
    mv_if.mv_ready = 1'b1;
    rst = 1'b1;
    #1;
    compared++;
    if (mv_if.mv_valid !== 1'b0 || mv_if.mv_dir !== 2'b00 || dist_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || status !== 2'b00) begin
      mismatched++; $display("FAIL rst_mid_emit_ctrl got v%b d%b en%b b%b dn%b st%b want all 0",
                             mv_if.mv_valid, mv_if.mv_dir, dist_en, busy, done, status);
    end
    @(posedge clk); @(negedge clk);
    compared++; if (cur_row !== 4'd0 || cur_col !== 4'd0 || step_cnt !== 7'd0 || mv_if.mv_valid !== 1'b0) begin mismatched++; $display("FAIL rst_no_move got %0d,%0d step %0d v%b want 0,0 step 0 v0", cur_row, cur_col, step_cnt, mv_if.mv_valid); end
    @(posedge clk); #1;
    rst = 1'b0; mv_if.mv_ready = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got no finish want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_open_maze();
    test_at_goal();
    test_unreachable();
    test_dead_end();
    test_timeout();
    test_bad_start();
    test_backpressure();
    test_open_maze();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
